// File: rtl/mem_if_pkg.sv
// Shared types and constants for the L1D <-> main-memory handshake.
package mem_if_pkg;

    localparam int WORDS_PER_LINE = 8;
    localparam int IDX_BITS       = $clog2(WORDS_PER_LINE);

    localparam logic [3:0] ACK_IDLE  = 4'hF;
    localparam logic [3:0] ACK_STORE = 4'h0;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        HANDSHAKE   = 3'd1,
        LD_READ     = 3'd2,
        LD_SEND     = 3'd3,
        ST_WAIT     = 3'd4,
        DONE        = 3'd5,
        ACCESS_WAIT = 3'd6
    } state_t;

    // 4'hF stays reserved for idle because the index never exceeds WORDS_PER_LINE-1.
    function automatic logic [3:0] idx_to_ack(input logic [IDX_BITS-1:0] k);
        return {{(4 - IDX_BITS){1'b0}}, k};
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, 32-bit words, read-first, one-cycle read latency.
module mem_array #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 CLK,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] mem_r [0:(2**ADDR_BITS)-1];
    logic [31:0] rdata_r;

    // Contents are never reset so data survives a responder reset.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata_r <= mem_r[addr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/main_memory_responder.sv
// Main-memory side of the L1D line-fill / word-store handshake.
// Optional access delay enabled with `define MEM_WAIT_EN (WAIT_CYCLES cycles per access).
module main_memory_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        VALID,
    input  logic        LOAD,
    input  logic        STORE,
    input  logic        ACK_ADDR,
    input  logic [3:0]  ACK_DATA_L1,
    input  logic [31:0] DATA_IN,
    output logic        READY,
    output logic        ADDR_TAKEN,
    output logic [3:0]  ACK_DATA_MEM,
    output logic [31:0] DATA_OUT
);

    state_t                 state_r, state_nxt_s;
    logic [ADDR_BITS-1:0]   addr_r, addr_nxt_s;
    logic [IDX_BITS-1:0]    k_r, k_nxt_s;
    logic                   out_vld_r, out_vld_nxt_s;
    logic                   ready_r, ready_nxt_s;
    logic                   addr_taken_r, addr_taken_nxt_s;
    logic [3:0]             ack_r, ack_nxt_s;
    logic [31:0]            dout_r, dout_nxt_s;
    logic                   mem_we_s;
    logic [ADDR_BITS-1:0]   mem_addr_s;
    logic [31:0]            mem_wdata_s;
    logic [31:0]            mem_rdata_s;
`ifdef MEM_WAIT_EN
    localparam int WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    logic [WCNT_W-1:0]      wcnt_r, wcnt_nxt_s;
    logic                   is_load_r, is_load_nxt_s;
    logic [31:0]            wdata_r, wdata_nxt_s;
`endif

    mem_array #(.ADDR_BITS(ADDR_BITS)) u_mem (
        .CLK   (CLK),
        .we    (mem_we_s),
        .addr  (mem_addr_s),
        .wdata (mem_wdata_s),
        .rdata (mem_rdata_s)
    );

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r      <= IDLE;
            addr_r       <= '0;
            k_r          <= '0;
            out_vld_r    <= 1'b0;
            ready_r      <= 1'b0;
            addr_taken_r <= 1'b0;
            ack_r        <= ACK_IDLE;
            dout_r       <= 32'h0000_0000;
`ifdef MEM_WAIT_EN
            wcnt_r       <= '0;
            is_load_r    <= 1'b0;
            wdata_r      <= 32'h0000_0000;
`endif
        end else begin
            state_r      <= state_nxt_s;
            addr_r       <= addr_nxt_s;
            k_r          <= k_nxt_s;
            out_vld_r    <= out_vld_nxt_s;
            ready_r      <= ready_nxt_s;
            addr_taken_r <= addr_taken_nxt_s;
            ack_r        <= ack_nxt_s;
            dout_r       <= dout_nxt_s;
`ifdef MEM_WAIT_EN
            wcnt_r       <= wcnt_nxt_s;
            is_load_r    <= is_load_nxt_s;
            wdata_r      <= wdata_nxt_s;
`endif
        end
    end

    // Next-state, RAM control and next output values.
    always_comb begin
        state_nxt_s      = state_r;
        addr_nxt_s       = addr_r;
        k_nxt_s          = k_r;
        out_vld_nxt_s    = out_vld_r;
        ready_nxt_s      = ready_r;
        addr_taken_nxt_s = 1'b0;
        ack_nxt_s        = ack_r;
        dout_nxt_s       = dout_r;
        mem_we_s         = 1'b0;
        mem_addr_s       = {addr_r[ADDR_BITS-1:IDX_BITS], k_r};
        mem_wdata_s      = DATA_IN;
`ifdef MEM_WAIT_EN
        wcnt_nxt_s       = wcnt_r;
        is_load_nxt_s    = is_load_r;
        wdata_nxt_s      = wdata_r;
`endif
        // Dropping VALID anywhere outside IDLE abandons the transaction, pending write included.
        if ((state_r != IDLE) && !VALID) begin
            state_nxt_s   = IDLE;
            ready_nxt_s   = 1'b0;
            ack_nxt_s     = ACK_IDLE;
            dout_nxt_s    = 32'h0000_0000;
            out_vld_nxt_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (VALID) begin
                        state_nxt_s = HANDSHAKE;
                        ready_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                HANDSHAKE: begin
                    if (ACK_ADDR && (LOAD || STORE)) begin
                        addr_nxt_s       = DATA_IN[ADDR_BITS-1:0];
                        addr_taken_nxt_s = 1'b1;
                        k_nxt_s          = '0;
                        out_vld_nxt_s    = 1'b0;
`ifdef MEM_WAIT_EN
                        is_load_nxt_s    = LOAD;
                        wcnt_nxt_s       = '0;
                        state_nxt_s      = LOAD ? ACCESS_WAIT : ST_WAIT;
`else
                        state_nxt_s      = LOAD ? LD_READ : ST_WAIT;
`endif
                    end else begin
                        state_nxt_s = HANDSHAKE;
                    end
                end
                LD_READ: begin
                    state_nxt_s   = LD_SEND;
                    out_vld_nxt_s = 1'b0;
                end
                LD_SEND: begin
                    // First LD_SEND cycle moves the RAM output into the output register.
                    if (!out_vld_r) begin
                        dout_nxt_s    = mem_rdata_s;
                        ack_nxt_s     = idx_to_ack(k_r);
                        out_vld_nxt_s = 1'b1;
                    end else if (ACK_DATA_L1 == idx_to_ack(k_r)) begin
                        if (k_r == IDX_BITS'(WORDS_PER_LINE - 1)) begin
                            state_nxt_s = DONE;
                        end else begin
                            k_nxt_s       = k_r + IDX_BITS'(1);
                            out_vld_nxt_s = 1'b0;
`ifdef MEM_WAIT_EN
                            wcnt_nxt_s    = '0;
                            state_nxt_s   = ACCESS_WAIT;
`else
                            state_nxt_s   = LD_READ;
`endif
                        end
                    end else begin
                        state_nxt_s = LD_SEND;
                    end
                end
                ST_WAIT: begin
                    if (ACK_DATA_L1 == ACK_STORE) begin
`ifdef MEM_WAIT_EN
                        wdata_nxt_s = DATA_IN;
                        wcnt_nxt_s  = '0;
                        state_nxt_s = ACCESS_WAIT;
`else
                        mem_we_s    = 1'b1;
                        mem_addr_s  = addr_r;
                        ack_nxt_s   = ACK_STORE;
                        state_nxt_s = DONE;
`endif
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
`ifdef MEM_WAIT_EN
                ACCESS_WAIT: begin
                    if (wcnt_r == WCNT_W'(WAIT_CYCLES - 1)) begin
                        wcnt_nxt_s = '0;
                        if (is_load_r) begin
                            state_nxt_s = LD_READ;
                        end else begin
                            mem_we_s    = 1'b1;
                            mem_addr_s  = addr_r;
                            mem_wdata_s = wdata_r;
                            ack_nxt_s   = ACK_STORE;
                            state_nxt_s = DONE;
                        end
                    end else begin
                        wcnt_nxt_s = wcnt_r + WCNT_W'(1);
                    end
                end
`endif
                DONE: begin
                    state_nxt_s = DONE;
                end
                default: begin
                    state_nxt_s   = IDLE;
                    ready_nxt_s   = 1'b0;
                    ack_nxt_s     = ACK_IDLE;
                    dout_nxt_s    = 32'h0000_0000;
                    out_vld_nxt_s = 1'b0;
                end
            endcase
        end
    end

    assign READY        = ready_r;
    assign ADDR_TAKEN   = addr_taken_r;
    assign ACK_DATA_MEM = ack_r;
    assign DATA_OUT     = dout_r;

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: directed table, corner sequences, random traffic vs. array model.
module tb_main_memory_responder;

`ifdef MEM_WAIT_EN
    localparam int W = 4;
`else
    localparam int W = 0;
`endif
    localparam int LD_LAT = 2 + W;   // cycles from capture/ack edge to word visible
    localparam int ST_LAT = W;       // cycles after the edge that samples ACK_DATA_L1=0

    logic        CLK, RST_N, VALID, LOAD, STORE, ACK_ADDR;
    logic [3:0]  ACK_DATA_L1;
    logic [31:0] DATA_IN;
    logic        READY, ADDR_TAKEN;
    logic [3:0]  ACK_DATA_MEM;
    logic [31:0] DATA_OUT;

    int errors = 0;
    int checks = 0;

    logic [31:0] mmem [0:1023];
    bit          mvld [0:1023];

    main_memory_responder #(.ADDR_BITS(10), .WAIT_CYCLES(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .VALID(VALID), .LOAD(LOAD), .STORE(STORE),
        .ACK_ADDR(ACK_ADDR), .ACK_DATA_L1(ACK_DATA_L1), .DATA_IN(DATA_IN),
        .READY(READY), .ADDR_TAKEN(ADDR_TAKEN), .ACK_DATA_MEM(ACK_DATA_MEM), .DATA_OUT(DATA_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Waits (bounded) for ACK_DATA_MEM to show exp; n = cycles waited.
    task automatic wait_ack(input logic [3:0] exp, output int n);
        n = 0;
        while (ACK_DATA_MEM !== exp && n < 30) begin
            step();
            n++;
        end
    endtask

    task automatic run_txn(input bit ld, input bit st, input logic [31:0] addr, input logic [31:0] wdata,
                           input int stop_at, input bit use_rst,
                           output logic [31:0] w0, output logic [31:0] w3);
        int n;
        logic [9:0] a, base, idx;
        logic [31:0] dsave;
        a = addr[9:0];
        base = {a[9:3], 3'b000};
        w0 = 32'hX; w3 = 32'hX;
        VALID = 1'b1; LOAD = ld; STORE = st; ACK_ADDR = 1'b0; ACK_DATA_L1 = 4'hF;
        step();
        check("ready_up", {31'd0, READY}, 32'd1);
        ACK_ADDR = 1'b1; DATA_IN = addr;
        step();
        check("addr_taken", {31'd0, ADDR_TAKEN}, 32'd1);
        ACK_ADDR = 1'b0; DATA_IN = $urandom;
        if (ld) begin
            for (int k = 0; k < 8; k++) begin
                wait_ack(4'(k), n);
                check("ld_latency", n, LD_LAT);
                check("ld_index", {28'd0, ACK_DATA_MEM}, k);
                idx = base + 10'(k);
                if (mvld[idx]) check("ld_data", DATA_OUT, mmem[idx]);
                if (k == 0) w0 = DATA_OUT;
                if (k == 3) w3 = DATA_OUT;
                if (k == stop_at && use_rst) begin
                    #2 RST_N = 1'b0;
                    #1;
                    check("rst_ready", {31'd0, READY}, 32'd0);
                    check("rst_ack", {28'd0, ACK_DATA_MEM}, 32'hF);
                    check("rst_data", DATA_OUT, 32'd0);
                    VALID = 1'b0; LOAD = 1'b0; STORE = 1'b0;
                    step();
                    RST_N = 1'b1;
                    step();
                    return;
                end
                dsave = DATA_OUT;
                repeat ($urandom_range(0, 2)) begin
                    ACK_DATA_L1 = (k == 0) ? 4'hF : 4'(k - 1);
                    step();
                    check("ld_hold_idx", {28'd0, ACK_DATA_MEM}, k);
                    check("ld_hold_data", DATA_OUT, dsave);
                end
                ACK_DATA_L1 = 4'(k);
                step();
                ACK_DATA_L1 = 4'hF;
                if (k == stop_at) begin
                    VALID = 1'b0;
                    step();
                    check("abort_ready", {31'd0, READY}, 32'd0);
                    check("abort_ack", {28'd0, ACK_DATA_MEM}, 32'hF);
                    check("abort_data", DATA_OUT, 32'd0);
                    LOAD = 1'b0; STORE = 1'b0;
                    return;
                end
            end
            check("ld_done_hold", {28'd0, ACK_DATA_MEM}, 32'd7);
        end else begin
            repeat ($urandom_range(0, 2)) begin
                step();
                check("st_no_early_ack", {28'd0, ACK_DATA_MEM}, 32'hF);
            end
            DATA_IN = wdata; ACK_DATA_L1 = 4'h0;
            step();
            ACK_DATA_L1 = 4'hF; DATA_IN = $urandom;
            wait_ack(4'h0, n);
            check("st_latency", n, ST_LAT);
            mmem[a] = wdata;
            mvld[a] = 1'b1;
        end
        VALID = 1'b0;
        step();
        check("end_ready", {31'd0, READY}, 32'd0);
        check("end_ack", {28'd0, ACK_DATA_MEM}, 32'hF);
        LOAD = 1'b0; STORE = 1'b0;
    endtask

    typedef struct {
        bit          ld;
        bit          st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_w0;
        logic [31:0] exp_w3;
    } vec_t;

    initial begin
        vec_t tbl [8];
        logic [31:0] w0, w3;
        tbl[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0A0A_0A0A, 32'h0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_0013, 32'hDEAD_BEEF, 32'h0, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_004B, 32'h0, 32'h0000_0100, 32'h0000_0103};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h0A0A_0A0A, 32'hDEAD_BEEF};
        tbl[4] = '{1'b0, 1'b1, 32'h0000_0003, 32'h55AA_55AA, 32'h0, 32'h0};
        tbl[5] = '{1'b0, 1'b1, 32'h0000_0800, 32'h1234_5678, 32'h0, 32'h0};
        tbl[6] = '{1'b1, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 32'h1234_5678, 32'h55AA_55AA};
        tbl[7] = '{1'b1, 1'b0, 32'h0000_0005, 32'h0, 32'h1234_5678, 32'h55AA_55AA};
        for (int i = 0; i < 1024; i++) mvld[i] = 1'b0;

        RST_N = 1'b0; VALID = 1'b0; LOAD = 1'b0; STORE = 1'b0; ACK_ADDR = 1'b0;
        ACK_DATA_L1 = 4'hF; DATA_IN = 32'd0;
        repeat (3) step();
        check("reset_ready", {31'd0, READY}, 32'd0);
        check("reset_addr_taken", {31'd0, ADDR_TAKEN}, 32'd0);
        check("reset_ack", {28'd0, ACK_DATA_MEM}, 32'hF);
        check("reset_data", DATA_OUT, 32'd0);
        RST_N = 1'b1;
        step();

        for (int i = 0; i < 8; i++)
            run_txn(1'b0, 1'b1, 32'h48 + 32'(i), 32'h100 + 32'(i), -1, 1'b0, w0, w3);

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i].ld, tbl[i].st, tbl[i].addr, tbl[i].wdata, -1, 1'b0, w0, w3);
            if (tbl[i].ld) begin
                check("tbl_w0", w0, tbl[i].exp_w0);
                check("tbl_w3", w3, tbl[i].exp_w3);
            end
        end

        // Reset while word 3 is being presented; the array must keep its contents.
        run_txn(1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b1, w0, w3);
        run_txn(1'b1, 1'b0, 32'h10, 32'h0, -1, 1'b0, w0, w3);
        check("persist_w3", w3, 32'hDEAD_BEEF);

        // VALID dropped after word 2 is acked, then a normal load.
        run_txn(1'b1, 1'b0, 32'h4B, 32'h0, 2, 1'b0, w0, w3);
        run_txn(1'b1, 1'b0, 32'h48, 32'h0, -1, 1'b0, w0, w3);
        check("post_abort_w0", w0, 32'h100);
        check("post_abort_w3", w3, 32'h103);

        for (int t = 0; t < 60; t++) begin
            int op, stop;
            op = $urandom_range(0, 3);
            stop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_txn(op != 2, op >= 2, $urandom & 32'h0000_0C3F, $urandom, stop, 1'b0, w0, w3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
